// File: rtl/dcache_fill_fsm_if.sv
// dcache_fill_fsm_if: miss request, memory port and array write bundle for the dcache fill FSM
interface dcache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic [6:0]  block_index;
  logic        write_data_array;
  logic [7:0]  word_enable;
  logic [15:0] cache_data_out;
  logic        write_tag_array;
  logic [7:0]  meta_data_out;
  logic        fill_done;
  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_read_en, memory_address, block_index, write_data_array,
           word_enable, cache_data_out, write_tag_array, meta_data_out, fill_done
  );
  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_read_en, memory_address, block_index, write_data_array,
           word_enable, cache_data_out, write_tag_array, meta_data_out, fill_done
  );
endinterface

// File: rtl/dcache_fill_fsm.sv
// dcache_fill_fsm: fetches a 16-byte block on a miss, writes it word by word, then writes valid+tag
module dcache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input logic               clk,
  input logic               rst,
  dcache_fill_fsm_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE_TAG} state_t;
  state_t      r_state;
  logic [3:0]  r_issue_cnt;
  logic [2:0]  r_ret_cnt;
  logic [11:0] r_blk;
  logic        w_fill;
  logic        w_req;
  logic        w_wr;
  if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_bad_cfg
    $error("dcache_fill_fsm: unsupported configuration");
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_blk       <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.miss_detected) begin
            r_blk       <= bus.miss_address[15:4];
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_state     <= FILL;
          end
        FILL: begin
          if (w_req) r_issue_cnt <= r_issue_cnt + 4'd1;
          if (w_wr) r_ret_cnt <= r_ret_cnt + 3'd1;
          if (w_wr && r_ret_cnt == 3'd7) r_state <= WRITE_TAG;
        end
        default: r_state <= IDLE;
      endcase
    end
  always_comb begin
    w_fill               = r_state == FILL;
    w_req                = w_fill && r_issue_cnt < 4'(WORDS_PER_BLOCK);
    w_wr                 = w_fill && bus.memory_data_valid;
    bus.fsm_busy         = r_state != IDLE;
    bus.mem_read_en      = w_req;
    bus.memory_address   = w_req ? {r_blk, r_issue_cnt[2:0], 1'b0} : 16'h0;
    bus.block_index      = r_blk[6:0];
    bus.write_data_array = w_wr;
    bus.word_enable      = w_wr ? 8'b1 << r_ret_cnt : 8'h0;
    bus.cache_data_out   = bus.memory_data;
    bus.write_tag_array  = r_state == WRITE_TAG;
    bus.fill_done        = r_state == WRITE_TAG;
    bus.meta_data_out    = {3'b100, r_blk[11:7]};
  end
endmodule

// File: tb/tb_dcache_fill_fsm.sv
// tb_dcache_fill_fsm: scoreboard bench with a 4-cycle memory model for the dcache fill FSM
module tb_dcache_fill_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dcache_fill_fsm_if bus();
  dcache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int due; logic [15:0] d;} ret_t;
  int checks = 0;
  int passes = 0;
  int cyc;
  logic [15:0] exp_req[$];
  logic [23:0] exp_wr[$];
  ret_t pend[$];
  int req_at[$];
  int wr_at[$];
  int tag_at[$];
  logic [7:0] tag_meta[$];
  logic [6:0] tag_idx[$];
  int busy_cnt, done_cnt;
  int m_cyc[2];
  logic [15:0] m_addr[2];
  bit m_exp[2];
  int gap_after, gap_left, ret_given, rst_cyc;
  bit spur, idle_mode;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic push_fill(input logic [15:0] a);
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back({a[15:4], 3'(i), 1'b0});
      exp_wr.push_back({8'(1 << i), 16'hA000 + 16'(i)});
    end
  endtask
  task automatic clr();
    exp_req.delete(); exp_wr.delete(); pend.delete();
    req_at.delete(); wr_at.delete(); tag_at.delete(); tag_meta.delete(); tag_idx.delete();
    cyc = 0; busy_cnt = 0; done_cnt = 0;
    m_cyc[0] = -1; m_cyc[1] = -1; m_exp[0] = 1'b0; m_exp[1] = 1'b0;
    gap_after = -1; gap_left = 0; ret_given = 0; rst_cyc = -1;
    spur = 1'b0; idle_mode = 1'b0;
  endtask
  task automatic idle_chk(input string tag);
    chk(tag, {bus.fsm_busy, bus.mem_read_en, bus.write_data_array, bus.word_enable, bus.write_tag_array,
              bus.fill_done, bus.memory_address, bus.block_index, bus.meta_data_out},
        {5'b0, 8'h00, 1'b0, 16'h0000, 7'h00, 8'h80});
  endtask
  task automatic tick();
    ret_t r;
    rst = (cyc == rst_cyc);
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0;
    for (int k = 0; k < 2; k++)
      if (cyc == m_cyc[k]) begin
        bus.miss_detected = 1'b1;
        bus.miss_address = m_addr[k];
        if (m_exp[k]) push_fill(m_addr[k]);
      end
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'h0;
    if (spur) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data = 16'hDEAD;
    end else if (gap_left > 0) gap_left--;
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      bus.memory_data_valid = 1'b1;
      bus.memory_data = r.d;
      ret_given++;
      if (ret_given == gap_after) gap_left = 3;
    end
    @(negedge clk);
    if (bus.fsm_busy) busy_cnt++;
    if (bus.fill_done) done_cnt++;
    if (bus.mem_read_en) begin
      req_at.push_back(cyc);
      pend.push_back('{cyc + 4, 16'hA000 + 16'(bus.memory_address[3:1])});
      if (exp_req.size() == 0) chk("req_extra", bus.mem_read_en, 0);
      else chk("req_addr", bus.memory_address, exp_req.pop_front());
    end
    if (bus.write_data_array) begin
      wr_at.push_back(cyc);
      if (exp_wr.size() == 0) chk("wr_extra", bus.write_data_array, 0);
      else chk("wr_we_data", {bus.word_enable, bus.cache_data_out}, exp_wr.pop_front());
    end
    if (bus.write_tag_array) begin
      tag_at.push_back(cyc);
      tag_meta.push_back(bus.meta_data_out);
      tag_idx.push_back(bus.block_index);
    end
    if (idle_mode) idle_chk("idle_outputs");
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic fill_chk(input string s, input int tagc, input int wlast, input int busy,
                          input logic [7:0] meta, input logic [6:0] idx);
    chk({s, "_nreq"}, req_at.size(), 8);
    chk({s, "_req_first"}, req_at[0], 1);
    chk({s, "_req_last"}, req_at[$], 8);
    chk({s, "_nwr"}, wr_at.size(), 8);
    chk({s, "_wr_first"}, wr_at[0], 5);
    chk({s, "_wr_last"}, wr_at[$], wlast);
    chk({s, "_ntag"}, tag_at.size(), 1);
    chk({s, "_tag_cyc"}, tag_at[0], tagc);
    chk({s, "_meta"}, tag_meta[0], meta);
    chk({s, "_index"}, tag_idx[0], idx);
    chk({s, "_done_cnt"}, done_cnt, 1);
    chk({s, "_busy_cnt"}, busy_cnt, busy);
    chk({s, "_busy_end"}, bus.fsm_busy, 0);
    chk({s, "_exp_left"}, exp_req.size() + exp_wr.size(), 0);
  endtask
  initial begin
    clr();
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    m_cyc[0] = 0; m_addr[0] = 16'h1234; m_exp[0] = 1'b1;
    repeat (17) tick();
    fill_chk("basic", 13, 12, 13, 8'h82, 7'h23);
    clr();
    gap_after = 4;
    m_cyc[0] = 0; m_addr[0] = 16'h1234; m_exp[0] = 1'b1;
    repeat (20) tick();
    fill_chk("stall", 16, 15, 16, 8'h82, 7'h23);
    clr();
    m_cyc[0] = 0; m_addr[0] = 16'h1230; m_exp[0] = 1'b1;
    m_cyc[1] = 6; m_addr[1] = 16'h5670;
    repeat (17) tick();
    fill_chk("busy_miss", 13, 12, 13, 8'h82, 7'h23);
    clr();
    m_cyc[0] = 0; m_addr[0] = 16'h1230; m_exp[0] = 1'b1;
    rst_cyc = 7;
    repeat (8) tick();
    exp_req.delete();
    exp_wr.delete();
    idle_mode = 1'b1;
    repeat (7) tick();
    chk("rst_wr_last", wr_at[$], 7);
    chk("rst_ntag", tag_at.size(), 0);
    chk("rst_req_last", req_at[$], 7);
    clr();
    idle_mode = 1'b1;
    spur = 1'b1;
    repeat (3) tick();
    spur = 1'b0;
    tick();
    chk("spur_nwr", wr_at.size(), 0);
    clr();
    m_cyc[0] = 0; m_addr[0] = 16'hFFFF; m_exp[0] = 1'b1;
    m_cyc[1] = 14; m_addr[1] = 16'h0040; m_exp[1] = 1'b1;
    repeat (31) tick();
    chk("top_nreq", req_at.size(), 16);
    chk("top_req_last", req_at[7], 8);
    chk("b2b_req_first", req_at[8], 15);
    chk("top_ntag", tag_at.size(), 2);
    chk("top_tag_cyc", tag_at[0], 13);
    chk("top_meta", tag_meta[0], 8'h9F);
    chk("top_index", tag_idx[0], 7'h7F);
    chk("b2b_tag_cyc", tag_at[1], 27);
    chk("b2b_meta", tag_meta[1], 8'h80);
    chk("b2b_index", tag_idx[1], 7'h04);
    chk("b2b_busy_cnt", busy_cnt, 26);
    chk("b2b_exp_left", exp_req.size() + exp_wr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dcache_fill_fsm.md
Name: dcache_fill_fsm

Overview:
- Miss handler that fills the data cache. When the cache signals a miss, it fetches the 16-byte block from main memory and writes it into the data array one word per returned beat.
- After the last word it writes the metadata (valid + tag) into the metadata array.
- Sits between the dcache arrays and the pipelined main-memory port.
- Drives the write side of the arrays: word enable, data write, metadata write.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; fixed by the array geometry, only 8 is supported.
- MEM_LATENCY, 4, nominal memory read latency in cycles; informational only, because the FSM tracks returns via memory_data_valid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE
- miss_address  in  16  byte address of the missing access
- fsm_busy  out  1  fill in progress; the pipeline stalls while high
- mem_read_en  out  1  memory read request this cycle
- memory_address  out  16  word-aligned request address
- memory_data  in  16  returned read data
- memory_data_valid  in  1  memory_data valid this cycle
- block_index  out  7  latched set index (miss_address[10:4]) used for array block select
- write_data_array  out  1  data array write strobe
- word_enable  out  8  one-hot word select for the data array write
- cache_data_out  out  16  data to the data array (memory_data passthrough)
- write_tag_array  out  1  metadata array write strobe
- meta_data_out  out  8  metadata word {1'b1 valid, 2'b00, tag[4:0]}; tag = latched miss_address[15:11]
- fill_done  out  1  one-cycle pulse when the fill completes

Behaviour:
- States: IDLE, FILL, WRITE_TAG. All state and counters are registered. Outputs are combinational from state, counters and memory_data_valid.
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; issue_cnt and ret_cnt clear to 0; the latched block address clears to 0.
  - All strobes are 0: fsm_busy, mem_read_en, write_data_array, write_tag_array, fill_done.
  - word_enable=0, memory_address=0, block_index=0, meta_data_out=0x80.
  - Reset mid-fill aborts immediately; no metadata write occurs and partially written words stay unvalidated.
- IDLE:
  - fsm_busy=0.
  - If miss_detected=1: latch miss_address[15:4], clear both counters, go to FILL next cycle.
  - There is no memory request in the miss cycle itself.
- FILL (fsm_busy=1):
  - Request side: while issue_cnt<8, mem_read_en=1 and memory_address={blk[15:4], issue_cnt[2:0], 1'b0}; issue_cnt increments every cycle. This gives 8 requests on 8 consecutive cycles with no stalls on the request side. At issue_cnt=8, mem_read_en=0.
  - Return side: on each memory_data_valid=1, write_data_array=1, word_enable=1<<ret_cnt, cache_data_out=memory_data, then ret_cnt increments.
  - Returns are in order. Gaps in valid are tolerated; the FSM stays in FILL until 8 returns are counted.
  - A return in the same cycle as a request is legal; both proceed.
  - When ret_cnt=7 and memory_data_valid=1, go to WRITE_TAG next cycle.
- WRITE_TAG (one cycle):
  - write_tag_array=1, meta_data_out={1'b1, 2'b00, blk[15:11]}, fsm_busy=1, fill_done=1.
  - Next state is IDLE.
  - fsm_busy drops in the following cycle, so the pipeline retries and hits.
- memory_data_valid outside FILL is ignored: no array write. This covers stale returns after a reset.
- miss_detected in FILL or WRITE_TAG is ignored; the latched address does not change.
- miss_detected in the cycle the FSM returns to IDLE (first IDLE cycle) starts a new fill.
- miss_address[3:0] is ignored; a fill always covers the whole aligned block.
- Address arithmetic is 16-bit with no carry out of the offset field. For block 0xFFF0 the requests are 0xFFF0..0xFFFE, with no wrap into the next block.
- Fill latency with MEM_LATENCY=4 and no valid gaps:
  - miss at cycle 0, FILL from cycle 1, requests in cycles 1–8.
  - Returns in cycles 5–12; WRITE_TAG in cycle 13; IDLE in cycle 14.
  - fsm_busy is high in cycles 1–13.

Test Plan:
- Basic fill: miss_address=0x1234, memory model with 4-cycle latency returning 0xA000+word → requests 0x1230, 0x1232..0x123E in cycles 1–8; word_enable 0x01..0x80 with data 0xA000..0xA007 in cycles 5–12; cycle 13 write_tag_array=1, meta_data_out=0x82, block_index=0x23, fill_done=1; fsm_busy low from cycle 14.
- Memory stall gaps: valid deasserted for 3 cycles after the 4th return → no writes during the gap; 8 writes total; WRITE_TAG 3 cycles later than the basic case (cycle 16); mem_read_en still only in cycles 1–8.
- Miss during busy: miss_detected=1 with 0x5670 in cycle 6 of a fill for 0x1230 → ignored; all requests and meta_data_out reflect 0x1230.
- Reset mid-fill: rst=1 at cycle 7 (after 2 returns), memory keeps returning → all outputs reset values from cycle 8; no further write_data_array; write_tag_array never asserts.
- Spurious valid in IDLE: memory_data_valid=1 with no miss → write_data_array=0, word_enable=0, fsm_busy=0.
- Top block 0xFFFF plus back-to-back miss: requests 0xFFF0..0xFFFE with no wrap; meta_data_out=0x9F, block_index=0x7F; a new miss asserted in the first IDLE cycle starts FILL the next cycle.
